// File: rtl/gs_pkg.sv
// Shared game-state encoding, winner codes and round constants used by the
// game-state controller, the KO tracker and the HUD renderer.
package gs_pkg;

    typedef enum logic [3:0] {
        GS_START     = 4'd0,
        GS_STARTGAME = 4'd1,
        GS_THREE     = 4'd2,
        GS_TWO       = 4'd3,
        GS_ONE       = 4'd4,
        GS_FIGHT     = 4'd5,
        GS_GAME      = 4'd6,
        GS_KO        = 4'd7
    } gamestate_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        TRK_IDLE,
        TRK_ARMED,
        TRK_DONE
    } trk_state_t;

    localparam int MAX_HP     = 100;
    localparam int ROUND_SECS = 99;
    localparam int FPS        = 60;

endpackage

// File: rtl/ko_fighter_hp.sv
// One fighter's health: HP register with saturating damage, post-hit
// invulnerability counter and the hit-accept (ready) signal.
module ko_fighter_hp
    import gs_pkg::*;
#(
    parameter int MAX_HP  = gs_pkg::MAX_HP,
    parameter int HP_W    = 7,
    parameter int DMG_W   = 6,
    parameter int IFRAMES = 30
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             st,
    input  logic             armed,
    input  logic             tick,
    input  logic             hit_valid,
    input  logic [DMG_W-1:0] hit_dmg,
    output logic             hit_ready,
    output logic [HP_W-1:0]  hp
);

    localparam int IF_W = $clog2(IFRAMES + 1);
    localparam int SW   = (HP_W > DMG_W) ? HP_W : DMG_W;

    logic [IF_W-1:0] iframe;
    logic [SW-1:0]   hp_ext;
    logic [SW-1:0]   dmg_ext;
    logic [HP_W-1:0] hp_after_hit;

    assign hp_ext       = SW'(hp);
    assign dmg_ext      = SW'(hit_dmg);
    // Damage at or above current HP clamps to zero instead of wrapping.
    assign hp_after_hit = (hp_ext > dmg_ext) ? HP_W'(hp_ext - dmg_ext) : '0;

    assign hit_ready = armed && (iframe == '0) && !st;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!Reset) begin
            hp     <= HP_W'(MAX_HP);
            iframe <= '0;
        end else if (st) begin
            hp     <= HP_W'(MAX_HP);
            iframe <= '0;
        end else if (hit_valid && hit_ready) begin
            hp     <= hp_after_hit;
            iframe <= IF_W'(IFRAMES);
        end else if (tick && (iframe != '0)) begin
            iframe <= iframe - 1'b1;
        end
    end

endmodule

// File: rtl/ko_tracker.sv
// Round-outcome tracker: frame tick detection, 99 s round timer, round FSM
// and KO/timeout/draw decision for the game-state controller.
module ko_tracker
    import gs_pkg::*;
#(
    parameter int MAX_HP     = gs_pkg::MAX_HP,
    parameter int HP_W       = 7,
    parameter int DMG_W      = 6,
    parameter int IFRAMES    = 30,
    parameter int ROUND_SECS = gs_pkg::ROUND_SECS,
    parameter int FPS        = gs_pkg::FPS
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [3:0]       gamestate,
    input  logic             st,
    input  logic             hit1_valid,
    input  logic [DMG_W-1:0] hit1_dmg,
    output logic             hit1_ready,
    input  logic             hit2_valid,
    input  logic [DMG_W-1:0] hit2_dmg,
    output logic             hit2_ready,
    output logic             ko,
    output logic [HP_W-1:0]  hp1,
    output logic [HP_W-1:0]  hp2,
    output logic [6:0]       timer,
    output logic [1:0]       winner
);

    localparam int SUB_W = (FPS > 1) ? $clog2(FPS) : 1;

    trk_state_t       state_q, state_d;
    logic             fc_q, fc_qq, tick;
    logic [SUB_W-1:0] sub_cnt;
    logic             armed;
    logic             round_over;
    winner_t          win_d;

    assign armed = (state_q == TRK_ARMED);

    ko_fighter_hp #(.MAX_HP(MAX_HP), .HP_W(HP_W), .DMG_W(DMG_W), .IFRAMES(IFRAMES)) u_p1 (
        .Clk(Clk), .Reset(Reset), .st(st), .armed(armed), .tick(tick),
        .hit_valid(hit1_valid), .hit_dmg(hit1_dmg), .hit_ready(hit1_ready), .hp(hp1)
    );

    ko_fighter_hp #(.MAX_HP(MAX_HP), .HP_W(HP_W), .DMG_W(DMG_W), .IFRAMES(IFRAMES)) u_p2 (
        .Clk(Clk), .Reset(Reset), .st(st), .armed(armed), .tick(tick),
        .hit_valid(hit2_valid), .hit_dmg(hit2_dmg), .hit_ready(hit2_ready), .hp(hp2)
    );

    // frame_clk is only sampled, never used as a clock; tick is a registered rising edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fc_q  <= 1'b0;
            fc_qq <= 1'b0;
            tick  <= 1'b0;
        end else begin
            fc_q  <= frame_clk;
            fc_qq <= fc_q;
            tick  <= fc_q && !fc_qq;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset || st) begin
            sub_cnt <= '0;
            timer   <= 7'(ROUND_SECS);
        end else if (armed && tick) begin
            if (sub_cnt == SUB_W'(FPS - 1)) begin
                sub_cnt <= '0;
                if (timer != '0) timer <= timer - 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        win_d      = WIN_NONE;
        round_over = (hp1 == '0) || (hp2 == '0) || (timer == '0);

        if (hp1 == '0 && hp2 == '0) win_d = WIN_DRAW;
        else if (hp1 == '0)         win_d = WIN_P2;
        else if (hp2 == '0)         win_d = WIN_P1;
        else if (hp1 > hp2)         win_d = WIN_P1;
        else if (hp2 > hp1)         win_d = WIN_P2;
        else                        win_d = WIN_DRAW;

        case (state_q)
            TRK_IDLE:  if (gamestate == GS_GAME) state_d = TRK_ARMED;
            TRK_ARMED: begin
                if (round_over)                 state_d = TRK_DONE;
                else if (gamestate != GS_GAME)  state_d = TRK_IDLE;
            end
            TRK_DONE:  state_d = TRK_DONE;
            default:   state_d = TRK_IDLE;
        endcase

        if (st) state_d = TRK_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= TRK_IDLE;
            ko      <= 1'b0;
            winner  <= WIN_NONE;
        end else begin
            state_q <= state_d;
            if (st) begin
                ko     <= 1'b0;
                winner <= WIN_NONE;
            end else if (armed && round_over) begin
                ko     <= 1'b1;
                winner <= win_d;
            end
        end
    end

endmodule

// File: tb/tb_ko_tracker.sv
// Self-checking bench for ko_tracker: directed scenarios plus a randomized
// hit/frame sequence checked against a tick-counting reference model.
module tb_ko_tracker;
    import gs_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [3:0] gamestate = 4'd0;
    logic       st = 1'b0;
    logic       hit1_valid = 1'b0;
    logic [5:0] hit1_dmg = '0;
    logic       hit1_ready;
    logic       hit2_valid = 1'b0;
    logic [5:0] hit2_dmg = '0;
    logic       hit2_ready;
    logic       ko;
    logic [6:0] hp1, hp2;
    logic [6:0] timer;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    ko_tracker dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .gamestate(gamestate), .st(st),
        .hit1_valid(hit1_valid), .hit1_dmg(hit1_dmg), .hit1_ready(hit1_ready),
        .hit2_valid(hit2_valid), .hit2_dmg(hit2_dmg), .hit2_ready(hit2_ready),
        .ko(ko), .hp1(hp1), .hp2(hp2), .timer(timer), .winner(winner)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // One frame: 2 Clk high, 2 Clk low; the tick's effect is visible when it returns.
    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1; cyc(2);
            frame_clk = 1'b0; cyc(2);
        end
    endtask

    task automatic restart();
        st = 1'b1; cyc(1);
        st = 1'b0; gamestate = 4'd6; cyc(1);
    endtask

    task automatic hit(input logic v1, input int d1, input logic v2, input int d2);
        hit1_valid = v1; hit1_dmg = 6'(d1);
        hit2_valid = v2; hit2_dmg = 6'(d2);
        cyc(1);
        hit1_valid = 1'b0; hit2_valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; gamestate = 4'd0; cyc(3);
        checks++; if (hp1 !== 7'd100 || hp2 !== 7'd100) begin errors++;
            $display("FAIL reset_hp got %0d/%0d want 100/100", hp1, hp2); end
        checks++; if (timer !== 7'd99) begin errors++;
            $display("FAIL reset_timer got %0d want 99", timer); end
        checks++; if (ko !== 1'b0 || winner !== 2'b00) begin errors++;
            $display("FAIL reset_ko got ko=%b win=%b want 0/00", ko, winner); end
        checks++; if (hit1_ready !== 1'b0 || hit2_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready got %b%b want 00", hit1_ready, hit2_ready); end
        Reset = 1'b1; gamestate = 4'd6; cyc(1);
        checks++; if (hit1_ready !== 1'b1 || hit2_ready !== 1'b1 || ko !== 1'b0) begin errors++;
            $display("FAIL arm_ready got %b%b ko=%b want 11 ko=0", hit1_ready, hit2_ready, ko); end
    endtask

    task automatic test_iframe();
        hit(1'b1, 25, 1'b0, 0);
        checks++; if (hp1 !== 7'd75) begin errors++;
            $display("FAIL iframe_hit got %0d want 75", hp1); end
        checks++; if (hit1_ready !== 1'b0 || hit2_ready !== 1'b1) begin errors++;
            $display("FAIL iframe_ready got %b%b want 01", hit1_ready, hit2_ready); end
        hit1_valid = 1'b1; hit1_dmg = 6'd25;
        frames(29);
        checks++; if (hit1_ready !== 1'b0 || hp1 !== 7'd75) begin errors++;
            $display("FAIL iframe_29 got rdy=%b hp=%0d want 0/75", hit1_ready, hp1); end
        frames(1);
        hit1_valid = 1'b0;
        checks++; if (hp1 !== 7'd50 || hit1_ready !== 1'b0) begin errors++;
            $display("FAIL iframe_held got hp=%0d rdy=%b want 50/0", hp1, hit1_ready); end
    endtask

    task automatic test_ko_p2();
        restart();
        hit(1'b0, 0, 1'b1, 45); frames(30);
        hit(1'b0, 0, 1'b1, 45); frames(30);
        checks++; if (hp2 !== 7'd10) begin errors++;
            $display("FAIL ko_setup got %0d want 10", hp2); end
        hit(1'b0, 0, 1'b1, 40);
        checks++; if (hp2 !== 7'd0 || ko !== 1'b0) begin errors++;
            $display("FAIL ko_sat got hp=%0d ko=%b want 0/0", hp2, ko); end
        cyc(1);
        checks++; if (ko !== 1'b1 || winner !== 2'b01) begin errors++;
            $display("FAIL ko_p1win got ko=%b win=%b want 1/01", ko, winner); end
        checks++; if (hit1_ready !== 1'b0 || hit2_ready !== 1'b0) begin errors++;
            $display("FAIL ko_ready got %b%b want 00", hit1_ready, hit2_ready); end
        hit(1'b1, 10, 1'b1, 10);
        checks++; if (hp1 !== 7'd100 || hp2 !== 7'd0) begin errors++;
            $display("FAIL ko_frozen got %0d/%0d want 100/0", hp1, hp2); end
    endtask

    task automatic test_st_priority();
        gamestate = 4'd0;
        st = 1'b1; hit1_valid = 1'b1; hit1_dmg = 6'd7;
        cyc(1);
        st = 1'b0; hit1_valid = 1'b0;
        checks++; if (hp1 !== 7'd100 || hp2 !== 7'd100 || timer !== 7'd99) begin errors++;
            $display("FAIL st_reload got %0d/%0d t=%0d want 100/100 t=99", hp1, hp2, timer); end
        checks++; if (ko !== 1'b0 || winner !== 2'b00) begin errors++;
            $display("FAIL st_clear got ko=%b win=%b want 0/00", ko, winner); end
        cyc(2);
        checks++; if (hit1_ready !== 1'b0) begin errors++;
            $display("FAIL st_idle got %b want 0", hit1_ready); end
        gamestate = 4'd6; cyc(1);
        checks++; if (hit1_ready !== 1'b1) begin errors++;
            $display("FAIL st_rearm got %b want 1", hit1_ready); end
        st = 1'b1; hit1_valid = 1'b1; hit1_dmg = 6'd7;
        #1;
        checks++; if (hit1_ready !== 1'b0) begin errors++;
            $display("FAIL st_ready_mask got %b want 0", hit1_ready); end
        cyc(1);
        st = 1'b0; hit1_valid = 1'b0;
        checks++; if (hp1 !== 7'd100) begin errors++;
            $display("FAIL st_drop got %0d want 100", hp1); end
        cyc(1);
    endtask

    task automatic test_leave_game();
        hit(1'b1, 10, 1'b0, 0);
        gamestate = 4'd5; cyc(1);
        checks++; if (hit2_ready !== 1'b0 || hp1 !== 7'd90) begin errors++;
            $display("FAIL leave_idle got rdy2=%b hp1=%0d want 0/90", hit2_ready, hp1); end
        frames(60);
        checks++; if (timer !== 7'd99 || hp1 !== 7'd90) begin errors++;
            $display("FAIL leave_hold got t=%0d hp1=%0d want 99/90", timer, hp1); end
        gamestate = 4'd6; cyc(1);
        checks++; if (hit1_ready !== 1'b1 || hit2_ready !== 1'b1) begin errors++;
            $display("FAIL leave_rearm got %b%b want 11", hit1_ready, hit2_ready); end
        frames(60);
        checks++; if (timer !== 7'd98) begin errors++;
            $display("FAIL leave_timer got %0d want 98", timer); end
    endtask

    task automatic test_draw();
        restart();
        hit(1'b1, 63, 1'b1, 63); frames(30);
        hit(1'b1, 32, 1'b1, 32); frames(30);
        checks++; if (hp1 !== 7'd5 || hp2 !== 7'd5) begin errors++;
            $display("FAIL draw_setup got %0d/%0d want 5/5", hp1, hp2); end
        hit(1'b1, 5, 1'b1, 5);
        checks++; if (hp1 !== 7'd0 || hp2 !== 7'd0) begin errors++;
            $display("FAIL draw_both got %0d/%0d want 0/0", hp1, hp2); end
        cyc(1);
        checks++; if (ko !== 1'b1 || winner !== 2'b11) begin errors++;
            $display("FAIL draw_ko got ko=%b win=%b want 1/11", ko, winner); end
    endtask

    task automatic test_timeout(input logic pre_hit, input logic [1:0] exp_win);
        restart();
        if (pre_hit) begin
            hit(1'b1, 20, 1'b1, 40);
            checks++; if (hp1 !== 7'd80 || hp2 !== 7'd60) begin errors++;
                $display("FAIL to_setup got %0d/%0d want 80/60", hp1, hp2); end
        end
        for (int k = 1; k < 99; k++) begin
            frames(60);
            checks++; if (timer !== 7'(99 - k)) begin errors++;
                $display("FAIL to_count got %0d want %0d", timer, 99 - k); end
        end
        frames(59);
        checks++; if (timer !== 7'd1 || ko !== 1'b0) begin errors++;
            $display("FAIL to_last got t=%0d ko=%b want 1/0", timer, ko); end
        frames(1);
        checks++; if (timer !== 7'd0 || ko !== 1'b1 || winner !== exp_win) begin errors++;
            $display("FAIL to_end got t=%0d ko=%b win=%b want 0/1/%b", timer, ko, winner, exp_win); end
        frames(60);
        checks++; if (timer !== 7'd0) begin errors++;
            $display("FAIL to_sat got %0d want 0", timer); end
    endtask

    task automatic test_reset_mid_iframe();
        restart();
        hit(1'b1, 3, 1'b0, 0);
        checks++; if (hit1_ready !== 1'b0 || hp1 !== 7'd97) begin errors++;
            $display("FAIL rst_setup got rdy=%b hp=%0d want 0/97", hit1_ready, hp1); end
        Reset = 1'b0; gamestate = 4'd0; hit2_valid = 1'b1; hit2_dmg = 6'd9;
        cyc(1);
        hit2_valid = 1'b0; Reset = 1'b1;
        checks++; if (hp1 !== 7'd100 || hp2 !== 7'd100) begin errors++;
            $display("FAIL rst_hp got %0d/%0d want 100/100", hp1, hp2); end
        cyc(3);
        checks++; if (hit1_ready !== 1'b0 || hit2_ready !== 1'b0) begin errors++;
            $display("FAIL rst_idle got %b%b want 00", hit1_ready, hit2_ready); end
        gamestate = 4'd6; cyc(1);
        checks++; if (hit1_ready !== 1'b1) begin errors++;
            $display("FAIL rst_iframe_clr got %b want 1", hit1_ready); end
    endtask

    // Reference model counts frames: ready is "30 frames since last accepted hit".
    task automatic test_random();
        int m_hp1, m_hp2, m_if1, m_if2, m_frames, nf, d1, d2;
        logic v1, v2, r1, r2;
        logic [1:0] m_win;
        restart();
        m_hp1 = 100; m_hp2 = 100; m_if1 = 0; m_if2 = 0; m_frames = 0;
        for (int it = 0; it < 80; it++) begin
            nf = $urandom_range(0, 12);
            frames(nf);
            m_frames += nf;
            m_if1 = (m_if1 > nf) ? m_if1 - nf : 0;
            m_if2 = (m_if2 > nf) ? m_if2 - nf : 0;
            checks++; if (timer !== 7'(99 - m_frames / 60)) begin errors++;
                $display("FAIL rnd_timer it=%0d got %0d want %0d", it, timer, 99 - m_frames / 60); end
            r1 = (m_if1 == 0); r2 = (m_if2 == 0);
            checks++; if (hit1_ready !== r1 || hit2_ready !== r2) begin errors++;
                $display("FAIL rnd_ready it=%0d got %b%b want %b%b", it, hit1_ready, hit2_ready, r1, r2); end
            v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1));
            d1 = $urandom_range(0, 20);    d2 = $urandom_range(0, 20);
            hit(v1, d1, v2, d2);
            if (v1 && r1) begin m_hp1 = (m_hp1 > d1) ? m_hp1 - d1 : 0; m_if1 = 30; end
            if (v2 && r2) begin m_hp2 = (m_hp2 > d2) ? m_hp2 - d2 : 0; m_if2 = 30; end
            checks++; if (hp1 !== 7'(m_hp1) || hp2 !== 7'(m_hp2)) begin errors++;
                $display("FAIL rnd_hp it=%0d got %0d/%0d want %0d/%0d", it, hp1, hp2, m_hp1, m_hp2); end
            if (m_hp1 == 0 || m_hp2 == 0) begin
                m_win = (m_hp1 == 0 && m_hp2 == 0) ? 2'b11 : (m_hp1 == 0) ? 2'b10 : 2'b01;
                cyc(1);
                checks++; if (ko !== 1'b1 || winner !== m_win) begin errors++;
                    $display("FAIL rnd_ko got ko=%b win=%b want 1/%b", ko, winner, m_win); end
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_iframe();
        test_ko_p2();
        test_st_priority();
        test_leave_game();
        test_draw();
        test_timeout(1'b0, 2'b11);
        test_timeout(1'b1, 2'b01);
        test_reset_mid_iframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
